oam_dma: RTL and testbench



---
 rtl/oam_dma.sv | 99 +++++++++
 tb/tb_oam_dma.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA initiator: copies 160 bytes from {src_page,8'h00} to FE00 over the byte-wide sram bus.
// Latency: 2 cycles per byte, busy for 320 cycles, done pulses in the cycle after the last write.
// No backpressure; a new start at any time restarts the copy. Optional: OAM_DMA_ECHO_EN folds echo pages E0..FF onto C0..DF.
module oam_dma (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [7:0]  src_page,
  output logic        busy,
  output logic        done,
  output logic [15:0] address,
  output logic        RE,
  output logic        WE,
  inout  wire  [7:0]  databus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [7:0] LAST_INDEX = 8'h9F;

  logic [1:0] state;
  logic [7:0] index;
  logic [7:0] page_q;
  logic [7:0] data_q;
  logic [7:0] page_d;

`ifdef OAM_DMA_ECHO_EN
  always_comb begin
    page_d = src_page;
    if (src_page >= 8'hE0) begin
      page_d = src_page - 8'h20;
    end
  end
`else
  always_comb begin
    page_d = src_page;
  end
`endif

  // Restart beats completion, so an aborted copy never reports done.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      index  <= 8'h00;
      page_q <= 8'h00;
      data_q <= 8'h00;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        page_q <= page_d;
        index  <= 8'h00;
        state  <= READ;
      end else begin
        case (state)
          READ: begin
            data_q <= databus;
            state  <= WRITE;
          end
          WRITE: begin
            if (index == LAST_INDEX) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              index <= index + 8'h01;
              state <= READ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    address = 16'h0000;
    RE      = 1'b0;
    WE      = 1'b0;
    busy    = 1'b0;
    case (state)
      READ: begin
        address = {page_q, index};
        RE      = 1'b1;
        busy    = 1'b1;
      end
      WRITE: begin
        address = {8'hFE, index};
        WE      = 1'b1;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  assign databus = WE ? data_q : 8'bz;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: sram model, expected bus events queued by stimulus, popped by a negedge monitor.
module tb_oam_dma;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [7:0]  src_page;
  logic        busy;
  logic        done;
  logic [15:0] address;
  logic        RE;
  logic        WE;
  wire  [7:0]  databus;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  dat;
  } ev_t;

  localparam logic [1:0] EV_R = 2'd0;
  localparam logic [1:0] EV_W = 2'd1;
  localparam logic [1:0] EV_D = 2'd2;

  ev_t        exp_q[$];
  logic [7:0] oam [0:159];
  logic       fill_req;
  logic [7:0] fill_val;
  int         cyc;
  int         start_cyc;
  int         busy_cnt;
  int         total;
  int         bad;
  logic       prev_re;
  logic [15:0] prev_addr;

  oam_dma dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .src_page (src_page),
    .busy     (busy),
    .done     (done),
    .address  (address),
    .RE       (RE),
    .WE       (WE),
    .databus  (databus)
  );

  // Source memory contents are a fixed function of the address.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    case (a[15:8])
      8'hC1:   return a[7:0] ^ 8'h5A;
      8'hD0:   return a[7:0] ^ 8'hA5;
      8'hC3:   return a[7:0] + 8'h01;
      8'hC2:   return a[7:0];
      8'hE2:   return ~a[7:0];
      default: return a[15:8] ^ a[7:0];
    endcase
  endfunction

  function automatic logic [7:0] latched_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_EN
    if (p >= 8'hE0) return p - 8'h20;
`endif
    return p;
  endfunction

  assign databus = (RE && !WE) ? src_byte(address) : 8'bz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill_req) begin
      for (int i = 0; i < 160; i++) oam[i] <= fill_val;
    end else if (WE && address[15:8] == 8'hFE && address[7:0] < 8'hA0) begin
      oam[address[7:0]] <= databus;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_xfer(input logic [7:0] page);
    for (int i = 0; i < 160; i++) begin
      exp_q.push_back('{kind: EV_R, addr: {page, i[7:0]}, dat: 8'h00});
      exp_q.push_back('{kind: EV_W, addr: {8'hFE, i[7:0]}, dat: src_byte({page, i[7:0]})});
    end
    exp_q.push_back('{kind: EV_D, addr: 16'h0000, dat: 8'h00});
  endtask

  task automatic pop_chk(input logic [1:0] kind, output ev_t e, output logic ok);
    ok = 1'b0;
    e  = '0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d with empty scoreboard addr=%h", kind, address);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind) begin
        bad++;
        $display("FAIL event_kind: got %0d expected %0d addr=%h", kind, e.kind, address);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: protocol checks every cycle plus scoreboard pops on RE, WE and done.
  always @(negedge clk) begin
    ev_t  e;
    logic ok;
    if (rst_b) begin
      if (start) begin
        start_cyc = cyc;
        busy_cnt  = 0;
      end
      chk("re_we_exclusive", {31'd0, RE & WE}, 32'd0);
      chk("busy_vs_strobes", {31'd0, busy}, {31'd0, RE | WE});
      if (!busy) begin
        chk("idle_address", {16'd0, address}, 32'd0);
        chk("idle_bus_released", {31'd0, (databus === 8'bz) || (databus === 8'h00)}, 32'd1);
      end
      if (RE) begin
        pop_chk(EV_R, e, ok);
        if (ok) chk("read_address", {16'd0, address}, {16'd0, e.addr});
      end
      if (WE) begin
        pop_chk(EV_W, e, ok);
        if (ok) begin
          chk("write_address", {16'd0, address}, {16'd0, e.addr});
          chk("write_data", {24'd0, databus}, {24'd0, e.dat});
        end
        chk("write_follows_read", {31'd0, prev_re && (prev_addr[7:0] == address[7:0])}, 32'd1);
      end
      if (done) begin
        pop_chk(EV_D, e, ok);
        chk("done_cycle", cyc - start_cyc, 32'd321);
        chk("busy_cycles", busy_cnt, 32'd320);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
      if (busy && cyc > start_cyc) busy_cnt++;
    end
    prev_re   = RE;
    prev_addr = address;
  end

  task automatic start_dma(input logic [7:0] p);
    @(posedge clk); #1;
    src_page = p;
    start    = 1'b1;
    push_xfer(latched_page(p));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill_oam(input logic [7:0] v);
    @(posedge clk); #1;
    fill_val = v;
    fill_req = 1'b1;
    @(posedge clk); #1;
    fill_req = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_oam(input string name, input int lo, input int hi, input logic [7:0] page);
    int errs = 0;
    for (int i = lo; i <= hi; i++) begin
      if (oam[i] !== src_byte({page, i[7:0]})) errs++;
    end
    chk(name, errs, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; start_cyc = 0; busy_cnt = 0;
    prev_re = 1'b0; prev_addr = 16'h0;
    start = 1'b0; src_page = 8'h00; fill_req = 1'b0; fill_val = 8'h00;
    rst_b = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_address", {16'd0, address}, 32'd0);
    chk("reset_re_we", {30'd0, RE, WE}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;

    // Idle stability: monitor checks idle outputs every cycle.
    repeat (1000) @(posedge clk);

    // Basic transfer.
    fill_oam(8'h00);
    start_dma(8'hC1);
    wait_drain("basic_drain", 400);
    chk_oam("basic_oam", 0, 159, 8'hC1);

    // Restart at WRITE(50).
    fill_oam(8'h00);
    start_dma(8'hC1);
    repeat (101) @(posedge clk);
    #1;
    chk("restart_at_write50", {15'd0, WE, address}, {15'd0, 1'b1, 16'hFE32});
    src_page = 8'hD0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_aborted_events", exp_q.size(), 32'd219);
    exp_q.delete();
    push_xfer(latched_page(8'hD0));
    chk_oam("restart_c1_part", 0, 50, 8'hC1);
    chk("restart_byte51_untouched", {24'd0, oam[51]}, 32'd0);
    wait_drain("restart_drain", 400);
    chk_oam("restart_d0_full", 0, 159, 8'hD0);

    // Reset during READ(80).
    fill_oam(8'h11);
    start_dma(8'hC3);
    repeat (160) @(posedge clk);
    #1;
    chk("reset_at_read80", {15'd0, RE, address}, {15'd0, 1'b1, 16'hC350});
    #2 rst_b = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_re_we", {30'd0, RE, WE}, 32'd0);
    chk("midreset_bus", {31'd0, (databus === 8'bz) || (databus === 8'h00)}, 32'd1);
    chk("midreset_aborted_events", exp_q.size(), 32'd161);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk_oam("midreset_written", 0, 79, 8'hC3);
    begin
      int keep = 0;
      for (int i = 80; i < 160; i++) if (oam[i] !== 8'h11) keep++;
      chk("midreset_unwritten", keep, 32'd0);
    end
    rst_b = 1'b1;
    repeat (400) @(posedge clk);

    // Echo page.
    fill_oam(8'h00);
    start_dma(8'hE2);
    wait_drain("echo_drain", 400);
    chk_oam("echo_oam", 0, 159, latched_page(8'hE2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
